ysyx_22040088_mdu_ctrl: RTL and testbench



---
 rtl/ysyx_22040088_mdu_ctrl_pkg.sv | 23 ++
 rtl/ysyx_22040088_div_step.sv | 20 ++
 rtl/ysyx_22040088_mdu_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ysyx_22040088_mdu_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040088_mdu_ctrl_pkg.sv
// Shared definitions for the RV64M word-op sequencer: op bit indices, FSM states,
// word width and the architectural special-case constants.
package ysyx_22040088_mdu_ctrl_pkg;

  localparam int MDU_OP_MULW  = 0;
  localparam int MDU_OP_DIVW  = 1;
  localparam int MDU_OP_REMW  = 2;
  localparam int MDU_OP_DIVUW = 3;
  localparam int MDU_OP_REMUW = 4;

  localparam int MDU_WLEN = 32;

  localparam logic [31:0] DIV0_Q    = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN_W = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ysyx_22040088_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// subtract the divisor when it fits.
module ysyx_22040088_div_step #(
  parameter int WLEN = 32
) (
  input  logic [WLEN:0]   rem,
  input  logic [WLEN-1:0] divisor,
  input  logic            dbit,
  output logic [WLEN:0]   rem_next,
  output logic            qbit
);

  logic [WLEN+1:0] trial;

  // One extra bit keeps the borrow visible as the sign of the trial subtraction.
  assign trial    = {rem, dbit} - {2'b00, divisor};
  assign qbit     = ~trial[WLEN+1];
  assign rem_next = qbit ? trial[WLEN:0] : {rem[WLEN-1:0], dbit};

endmodule

// File: rtl/ysyx_22040088_mdu_ctrl.sv
// Multi-cycle sequencer for mulw/divw/remw/divuw/remuw with sign-extended result.
// Optional MDU_EARLY_TERM_EN skips leading zeros of the dividend before dividing.
module ysyx_22040088_mdu_ctrl
  import ysyx_22040088_mdu_ctrl_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int WLEN = MDU_WLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            stall,
  output logic            illegal
);

  localparam int CW = $clog2(WLEN);

  state_t          state;
  logic [WLEN-1:0] a_q, b_q, quo_q;
  logic [WLEN:0]   rem_q;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r, is_rem;

  logic [WLEN-1:0] a_w, b_w, a_abs, b_abs, prod;
  logic            op_signed, op_rem, accept, div_zero, ovf;
  logic [WLEN-1:0] spec_q, spec_r;
  logic            special;
  logic [WLEN:0]   rem_nx;
  logic            qbit;
  logic [WLEN-1:0] quo_nx, q_fix, r_fix;
  logic            unused_hi;

  function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] w);
    return {{(XLEN-WLEN){w[WLEN-1]}}, w};
  endfunction

  assign a_w       = src1[WLEN-1:0];
  assign b_w       = src2[WLEN-1:0];
  assign unused_hi = ^{src1[XLEN-1:WLEN], src2[XLEN-1:WLEN]};

  assign in_ready  = rst_n && (state == S_IDLE);
  assign stall     = (state != S_IDLE);
  assign accept    = in_valid && in_ready && !flush && $onehot(op);

  assign op_signed = op[MDU_OP_DIVW] | op[MDU_OP_REMW];
  assign op_rem    = op[MDU_OP_REMW] | op[MDU_OP_REMUW];
  assign a_abs     = (op_signed && a_w[WLEN-1]) ? -a_w : a_w;
  assign b_abs     = (op_signed && b_w[WLEN-1]) ? -b_w : b_w;
  assign div_zero  = (b_w == '0);
  assign ovf       = op_signed && (a_w == INT_MIN_W) && (b_w == '1);

`ifdef MDU_EARLY_TERM_EN
  function automatic logic [CW-1:0] clz(input logic [WLEN-1:0] v);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = WLEN - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 1'b1;
      end
    end
    return n;
  endfunction

  logic [CW-1:0] lz;
  assign lz = clz(a_abs);
`endif

  // Results that need no iteration, in priority order.
  always_comb begin
    special = 1'b1;
    spec_q  = '0;
    spec_r  = '0;
    if (div_zero) begin
      spec_q = DIV0_Q;
      spec_r = a_w;
    end else if (ovf) begin
      spec_q = INT_MIN_W;
      spec_r = '0;
`ifdef MDU_EARLY_TERM_EN
    end else if (a_w == '0) begin
      spec_q = '0;
      spec_r = '0;
`endif
    end else begin
      special = 1'b0;
    end
  end

  ysyx_22040088_div_step #(.WLEN(WLEN)) u_step (
    .rem      (rem_q),
    .divisor  (b_q),
    .dbit     (a_q[WLEN-1]),
    .rem_next (rem_nx),
    .qbit     (qbit)
  );

  assign quo_nx = {quo_q[WLEN-2:0], qbit};
  assign q_fix  = neg_q ? -quo_nx : quo_nx;
  assign r_fix  = neg_r ? -rem_nx[WLEN-1:0] : rem_nx[WLEN-1:0];
  assign prod   = a_q * b_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      is_rem    <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      illegal <= in_valid && in_ready && !flush && (op != '0) && !$onehot(op);
      if (flush) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              if (op[MDU_OP_MULW]) begin
                a_q   <= a_w;
                b_q   <= b_w;
                state <= S_MUL;
              end else if (special) begin
                result    <= sext_w(op_rem ? spec_r : spec_q);
                out_valid <= 1'b1;
                state     <= S_DONE;
              end else begin
                b_q    <= b_abs;
                rem_q  <= '0;
                quo_q  <= '0;
                neg_q  <= op_signed && (a_w[WLEN-1] ^ b_w[WLEN-1]);
                neg_r  <= op_signed && a_w[WLEN-1];
                is_rem <= op_rem;
`ifdef MDU_EARLY_TERM_EN
                a_q    <= a_abs << lz;
                cnt    <= CW'(WLEN - 1) - lz;
`else
                a_q    <= a_abs;
                cnt    <= CW'(WLEN - 1);
`endif
                state  <= S_DIV;
              end
            end
          end
          S_MUL: begin
            result    <= sext_w(prod);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
          S_DIV: begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            a_q   <= a_q << 1;
            cnt   <= cnt - 1'b1;
            // Last step: fold the sign fix-up straight into the result register.
            if (cnt == '0) begin
              result    <= sext_w(is_rem ? r_fix : q_fix);
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
          S_DONE: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_mdu_ctrl.sv
// Directed + scoreboard bench for ysyx_22040088_mdu_ctrl.
module tb_ysyx_22040088_mdu_ctrl;

  localparam logic [4:0] MULW  = 5'b00001;
  localparam logic [4:0] DIVW  = 5'b00010;
  localparam logic [4:0] REMW  = 5'b00100;
  localparam logic [4:0] DIVUW = 5'b01000;
  localparam logic [4:0] REMUW = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, stall, illegal;
  logic [4:0]  op;
  logic [63:0] src1, src2, result;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ysyx_22040088_mdu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .stall     (stall),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [31:0]        a32, b32, r;
    logic signed [31:0] sa, sb;
    logic               ov;
    a32 = a[31:0];
    b32 = b[31:0];
    sa  = a32;
    sb  = b32;
    ov  = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
    r   = '0;
    case (o)
      MULW:  r = a32 * b32;
      DIVW:  r = (b32 == 0) ? 32'hFFFF_FFFF : ov ? a32 : 32'(sa / sb);
      REMW:  r = (b32 == 0) ? a32 : ov ? 32'h0 : 32'(sa % sb);
      DIVUW: r = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
      REMUW: r = (b32 == 0) ? a32 : a32 % b32;
      default: r = '0;
    endcase
    return {{32{r[31]}}, r};
  endfunction

  function automatic int exp_lat(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, mag;
    logic        sgn;
    int          msb;
    a32 = a[31:0];
    b32 = b[31:0];
    sgn = (o == DIVW) || (o == REMW);
    if (o == MULW) return 2;
    if (b32 == 0) return 1;
    if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 1;
    mag = (sgn && a32[31]) ? (~a32 + 32'd1) : a32;
    msb = -1;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
`ifdef MDU_EARLY_TERM_EN
    if (msb < 0) return 1;
    return msb + 2;
`else
    return 33;
`endif
  endfunction

  task automatic run_op(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input string tag);
    int lat, n;
    bit stall_ok;
    lat = exp_lat(o, a, b);
    in_valid = 1'b1;
    op = o;
    src1 = a;
    src2 = b;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    op = '0;
    exp_q.push_back(exp);
    n = 1;
    stall_ok = 1'b1;
    while (!out_valid && n < 100) begin
      if (!stall) stall_ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    chk({tag, "_stall_done"}, 64'(stall), 64'd1);
    chk({tag, "_result"}, result, exp_q.pop_front());
    tick();
    chk({tag, "_released"}, {62'd0, out_valid, stall}, 64'd0);
  endtask

  initial begin
    bit seen;
    int n;
    logic [4:0] ops[5];
    logic [63:0] ra, rb;
    ops = '{MULW, DIVW, REMW, DIVUW, REMUW};

    rst_n = 1'b0; in_valid = 1'b0; op = '0; src1 = '0; src2 = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_outs", {60'd0, out_valid, stall, illegal, 1'b0}, 64'd0);
    chk("rst_result", result, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    run_op(MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mulw_max");
    run_op(DIVW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "divw_m7_2");
    run_op(REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "remw_m7_2");
    run_op(DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, "divuw_max_2");
    run_op(DIVW, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "divw_by0");
    run_op(REMW, 64'd5, 64'd0, 64'd5, "remw_by0");
    run_op(DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, "divw_ovf");
    run_op(REMW, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, "remw_ovf");
    run_op(DIVUW, 64'd1, 64'd1, 64'd1, "divuw_1_1");
    run_op(REMUW, 64'hDEAD_0000_8000_0007, 64'h1234_0000_0000_0010, 64'd7, "remuw_hi_ignored");

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_op(ops[i % 5], ra, rb, model(ops[i % 5], ra, rb), "random");
    end

    // Flush in the middle of a divide.
    in_valid = 1'b1; op = DIVW; src1 = 64'd100; src2 = 64'd7;
    tick();
    in_valid = 1'b0; op = '0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_stall", 64'(stall), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    run_op(MULW, 64'd3, 64'd4, 64'd12, "mulw_after_flush");

    // Back-pressure on the result.
    out_ready = 1'b0;
    in_valid = 1'b1; op = DIVW; src1 = 64'd20; src2 = 64'd3;
    tick();
    in_valid = 1'b0; op = '0;
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("bp_latency", 64'(n), 64'(exp_lat(DIVW, 64'd20, 64'd3)));
    repeat (5) begin
      chk("bp_hold", {result, 3'b0}, {64'd6, 3'b0});
      chk("bp_ctrl", {61'd0, out_valid, stall, in_ready}, 64'b110);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", {61'd0, out_valid, stall, in_ready}, 64'b001);

    // Non-one-hot op.
    in_valid = 1'b1; op = 5'b00011; src1 = 64'd9; src2 = 64'd3;
    tick();
    in_valid = 1'b0; op = '0;
    chk("illegal_pulse", {61'd0, illegal, stall, in_ready}, 64'b101);
    tick();
    chk("illegal_clear", 64'(illegal), 64'd0);

    // op = 0 is ignored.
    in_valid = 1'b1; op = 5'b00000;
    tick();
    in_valid = 1'b0;
    chk("op0_ignored", {62'd0, stall, illegal}, 64'd0);

    // Flush beats a request in IDLE.
    flush = 1'b1; in_valid = 1'b1; op = MULW; src1 = 64'd2; src2 = 64'd2;
    tick();
    flush = 1'b0; in_valid = 1'b0; op = '0;
    chk("flush_idle_stall", 64'(stall), 64'd0);
    tick();
    chk("flush_idle_no_out", {62'd0, out_valid, stall}, 64'd0);

    // Flush coinciding with the output handshake discards the result.
    in_valid = 1'b1; op = DIVW; src1 = 64'd5; src2 = 64'd0;
    tick();
    in_valid = 1'b0; op = '0;
    chk("flush_hs_ready", 64'(out_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_hs_after", {62'd0, out_valid, stall}, 64'd0);

    // Reset mid-operation.
    in_valid = 1'b1; op = DIVUW; src1 = 64'd1000; src2 = 64'd3;
    tick();
    in_valid = 1'b0; op = '0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_ctrl", {61'd0, out_valid, stall, in_ready}, 64'd0);
    chk("midrst_result", result, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("midrst_ready", 64'(in_ready), 64'd1);
    run_op(REMW, 64'd17, 64'hFFFF_FFFF_FFFF_FFFB, 64'd2, "remw_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
